result_drain: RTL and testbench
===============================

# result_drain

Reads a row of 8-bit results out of the systolic array's output registers and streams them out one byte per cycle. A parallel load captures all lanes in one cycle. The block then serialises them lane 0 first over a valid/ready byte interface toward the host-side output port. It is the consumer end of the PE output register row.

## Interface
- NUM_LANES, 4, number of 8-bit lanes captured per load (≥2)
- LANE_W, 8, bits per lane (fixed at 8 for this design)
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  synchronous, active-low reset
- load_valid  input  1  load_data holds a complete result row
- load_ready  output  1  block can accept a row this cycle
- load_data  input  NUM_LANES*8  lane i at bits [8i+7:8i]
- out_valid  output  1  out_data/out_index/out_last are valid
- out_ready  input  1  downstream accepts the byte this cycle
- out_data  output  8  current lane byte
- out_index  output  $clog2(NUM_LANES)  lane number of out_data
- out_last  output  1  current byte is lane NUM_LANES-1
- rows_done  output  16  count of fully drained rows, wraps at 2^16

## Operation
- States: IDLE, STREAM.
- IDLE: load_ready=1, out_valid=0. On load_valid&&load_ready, capture all lanes into the buffer, set index=0, and go to STREAM.
- STREAM: out_valid=1, out_data=buffer[index], out_index=index, out_last=(index==NUM_LANES-1).
  - On out_valid&&out_ready with !out_last: index+1.
  - On a handshake with out_last: rows_done+1. Then, if load_valid is high that same cycle, capture the new row, set index=0, and stay in STREAM. Otherwise go to IDLE.
- load_ready = IDLE || (STREAM && out_last && out_ready). This gives back-to-back rows with no bubble.
- Backpressure: while out_valid && !out_ready, out_data, out_index and out_last hold stable. No load is accepted.
- The buffer is written only on an accepted load. Lanes already sent are not cleared.
- Reset (reset==0), at any time including mid-row:
  - state goes to IDLE, index=0, buffer=0, rows_done=0;
  - load_ready and out_valid are forced to 0 while reset is low;
  - the partially drained row is discarded and is not counted.
- Reset behaviour holds regardless of load_valid/out_ready.

## Timing
- Load latency: row accepted at edge T, so lane 0 is presented with out_valid=1 in cycle T+1.
- Throughput: one byte per cycle with out_ready held high. NUM_LANES cycles per row, no gap between rows.
- out_last asserts in the cycle lane NUM_LANES-1 is presented.
- rows_done updates on the edge of the final handshake. It is visible the next cycle.
- All outputs are decoded from registered state with no input-to-output combinational path, except load_ready. load_ready depends combinationally on out_ready.
- Output values while reset is low, and in the cycle after reset releases: out_valid=0, out_data=0, out_index=0, out_last=0, rows_done=0. load_ready is 0 while reset is low and 1 from the first cycle after release.

## Structure
- Shared package holds:
  - state enum {IDLE, STREAM};
  - LANE_W constant;
  - lane-index width helper (clog2 of NUM_LANES).
- One natural sub-module, drain_lane_buffer. It is NUM_LANES×8-bit storage with a single load enable, synchronous active-low reset and an index-selected read port.
- The FSM, index counter, handshake logic and rows_done counter live in result_drain.

## Test plan
- Basic drain: NUM_LANES=4, reset, load 0x44332211, out_ready=1.
  - out_data 0x11,0x22,0x33,0x44 on cycles T+1..T+4.
  - out_index 0..3, out_last only on 0x44.
  - rows_done=1, then IDLE.
- Backpressure: out_ready low for 3 cycles while showing 0x22.
  - 0x22 and out_index=1 hold stable.
  - No byte is lost or duplicated; sequence completes.
- Back-to-back rows: load_valid held with 0x44332211 then 0xDDCCBBAA.
  - 8 consecutive bytes, no bubble.
  - load_ready pulses exactly on the final byte of row 1; rows_done=2.
- Load blocked: assert load_valid mid-row (index 1) with 0xFFFFFFFF.
  - load_ready=0; current row outputs unchanged.
  - New row is taken only at the last-byte handshake.
- Reset mid-row: drop reset while showing 0x33.
  - Next cycle: out_valid=0, rows_done unchanged from 0, buffer cleared.
  - After release, load_ready=1 and a new load drains correctly.
- Counter wrap: preload by draining 65536 rows (or force-test rows_done=0xFFFF).
  - The next completed row gives rows_done=0x0000.

Source files
------------

// File: rtl/result_drain_pkg.sv
// Shared types and constants for the result row drain path.
// Holds the drain FSM encoding, the lane width and the lane-index width helper.
package result_drain_pkg;

    typedef enum logic [0:0] {
        DRAIN_IDLE   = 1'b0,
        DRAIN_STREAM = 1'b1
    } drain_state_e;

    localparam int LANE_W = 8;
    localparam int ROWS_W = 16;

    // Index width for a lane counter; never narrower than one bit.
    function automatic int lane_idx_w(input int num_lanes);
        if (num_lanes <= 2) begin
            return 1;
        end else begin
            return $clog2(num_lanes);
        end
    endfunction

endpackage

// File: rtl/result_drain_lane_buffer.sv
// Row storage for result_drain: NUM_LANES bytes written together on a load,
// read back one lane at a time through an index-selected port.
module drain_lane_buffer
    import result_drain_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int IDX_W     = lane_idx_w(NUM_LANES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_load_en,
    input  logic [NUM_LANES*LANE_W-1:0] i_load_data,
    input  logic [IDX_W-1:0]            i_rd_idx,
    output logic [LANE_W-1:0]           o_rd_data
);

    logic [LANE_W-1:0] r_lanes [NUM_LANES];

    // Lane storage: cleared by reset, overwritten only by an accepted load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_lanes[i] <= {LANE_W{1'b0}};
            end
        end else if (i_load_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_lanes[i] <= i_load_data[i*LANE_W +: LANE_W];
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_lanes[i] <= r_lanes[i];
            end
        end
    end

    // Read port; the index counter never leaves 0..NUM_LANES-1.
    always_comb begin
        o_rd_data = r_lanes[i_rd_idx];
    end

endmodule

// File: rtl/result_drain.sv
// Drains one row of PE results into a valid/ready byte stream, lane 0 first,
// with a bubble-free reload on the final byte handshake.
module result_drain
    import result_drain_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int IDX_W     = lane_idx_w(NUM_LANES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [NUM_LANES*LANE_W-1:0] load_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANE_W-1:0]           out_data,
    output logic [IDX_W-1:0]            out_index,
    output logic                        out_last,
    output logic [ROWS_W-1:0]           rows_done
);

    localparam logic [0:0]       S_IDLE   = DRAIN_IDLE;
    localparam logic [0:0]       S_STREAM = DRAIN_STREAM;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_index;
    logic [ROWS_W-1:0] r_rows_done;

    logic [0:0]        w_state_nx;
    logic [IDX_W-1:0]  w_index_nx;
    logic [ROWS_W-1:0] w_rows_nx;

    logic              w_streaming;
    logic              w_at_last;
    logic              w_last_fire;
    logic              w_load_ready;
    logic              w_load_fire;
    logic [LANE_W-1:0] w_rd_data;

    // Handshake decode; load_ready is the only output that sees out_ready.
    always_comb begin
        w_streaming  = (r_state == S_STREAM);
        w_at_last    = w_streaming && (r_index == LAST_IDX);
        w_last_fire  = w_at_last && out_ready;
        w_load_ready = reset && (!w_streaming || w_last_fire);
        w_load_fire  = load_valid && w_load_ready;
    end

    // Next-state, lane index and completed-row count.
    always_comb begin
        w_state_nx = r_state;
        w_index_nx = r_index;
        w_rows_nx  = r_rows_done;
        case (r_state)
            S_IDLE: begin
                if (w_load_fire) begin
                    w_state_nx = S_STREAM;
                    w_index_nx = {IDX_W{1'b0}};
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_STREAM: begin
                if (!out_ready) begin
                    w_state_nx = S_STREAM;
                end else if (!w_at_last) begin
                    w_index_nx = r_index + IDX_W'(1);
                end else begin
                    // Final byte accepted: count it, then reload or go idle.
                    w_rows_nx  = r_rows_done + 16'd1;
                    w_index_nx = {IDX_W{1'b0}};
                    if (load_valid) begin
                        w_state_nx = S_STREAM;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_index_nx = {IDX_W{1'b0}};
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_index     <= {IDX_W{1'b0}};
            r_rows_done <= {ROWS_W{1'b0}};
        end else begin
            r_state     <= w_state_nx;
            r_index     <= w_index_nx;
            r_rows_done <= w_rows_nx;
        end
    end

    drain_lane_buffer #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (IDX_W)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .i_load_en   (w_load_fire),
        .i_load_data (load_data),
        .i_rd_idx    (r_index),
        .o_rd_data   (w_rd_data)
    );

    // Outputs are quiet while reset is held and whenever no byte is offered.
    always_comb begin
        load_ready = w_load_ready;
        out_valid  = reset && w_streaming;
        out_last   = reset && w_at_last;
        if (reset && w_streaming) begin
            out_data  = w_rd_data;
            out_index = r_index;
        end else begin
            out_data  = {LANE_W{1'b0}};
            out_index = {IDX_W{1'b0}};
        end
        if (reset) begin
            rows_done = r_rows_done;
        end else begin
            rows_done = {ROWS_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: directed scenarios plus random traffic,
// all compared each cycle against a queue-based model of the byte stream.
module tb_result_drain;

    localparam int NL = 4;

    logic        clk;
    logic        rst;
    logic        lv;
    logic        lr;
    logic [31:0] ld;
    logic        ov;
    logic        ordy;
    logic [7:0]  od;
    logic [1:0]  oidx;
    logic        olast;
    logic [15:0] orows;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: bytes still to be sent for the current row, and rows completed.
    logic [7:0]  m_q[$];
    logic [15:0] m_rows = 16'd0;

    logic [31:0] obs_lr, obs_valid, obs_data, obs_idx, obs_last, obs_rows;
    logic [7:0]  exp_b [8];
    int          pulses;

    result_drain #(.NUM_LANES(NL)) dut (
        .clk        (clk),
        .reset      (rst),
        .load_valid (lv),
        .load_ready (lr),
        .load_data  (ld),
        .out_valid  (ov),
        .out_ready  (ordy),
        .out_data   (od),
        .out_index  (oidx),
        .out_last   (olast),
        .rows_done  (orows)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        int          sz;
        logic        take;
        logic [7:0]  dummy;
        @(negedge clk);
        obs_lr    = 32'(lr);
        obs_valid = 32'(ov);
        obs_data  = 32'(od);
        obs_idx   = 32'(oidx);
        obs_last  = 32'(olast);
        obs_rows  = 32'(orows);
        sz = m_q.size();
        chk("load_ready", obs_lr, 32'(rst && (sz == 0 || (sz == 1 && ordy))));
        chk("out_valid",  obs_valid, 32'(rst && sz != 0));
        chk("out_last",   obs_last,  32'(rst && sz == 1));
        chk("rows_done",  obs_rows,  rst ? 32'(m_rows) : 32'd0);
        if (rst && sz != 0) begin
            chk("out_data",  obs_data, 32'(m_q[0]));
            chk("out_index", obs_idx,  32'(NL - sz));
        end else if (!rst) begin
            chk("out_data_rst",  obs_data, 32'd0);
            chk("out_index_rst", obs_idx,  32'd0);
        end
        @(posedge clk);
        if (!rst) begin
            m_q.delete();
            m_rows = 16'd0;
        end else begin
            take = (sz == 0) || (sz == 1 && ordy);
            if (sz != 0 && ordy) begin
                dummy = m_q.pop_front();
                if (m_q.size() == 0) m_rows = m_rows + 16'd1;
            end
            if (take && lv) begin
                for (int i = 0; i < NL; i++) m_q.push_back(ld[i*8 +: 8]);
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b0; lv = 1'b0; ordy = 1'b0; ld = 32'd0;

        // Reset held, then first cycle after release.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_load_ready", obs_lr, 32'd0);
            chk("rst_out_valid", obs_valid, 32'd0);
            chk("rst_rows", obs_rows, 32'd0);
        end
        rst = 1'b1;
        step();
        chk("post_rst_load_ready", obs_lr, 32'd1);
        chk("post_rst_out_valid", obs_valid, 32'd0);
        chk("post_rst_out_data", obs_data, 32'd0);

        // Basic drain.
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        exp_b[4] = 8'hAA; exp_b[5] = 8'hBB; exp_b[6] = 8'hCC; exp_b[7] = 8'hDD;
        lv = 1'b1; ld = 32'h44332211; ordy = 1'b1;
        step();
        lv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("basic_valid", obs_valid, 32'd1);
            chk("basic_data", obs_data, 32'(exp_b[i]));
            chk("basic_index", obs_idx, 32'(i));
            chk("basic_last", obs_last, 32'(i == 3));
        end
        step();
        chk("basic_idle", obs_valid, 32'd0);
        chk("basic_rows", obs_rows, 32'd1);

        // Backpressure while 0x22 is shown.
        lv = 1'b1; ld = 32'h44332211;
        step();
        lv = 1'b0;
        step();
        chk("bp_first", obs_data, 32'h11);
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_data", obs_data, 32'h22);
            chk("bp_hold_index", obs_idx, 32'd1);
            chk("bp_hold_valid", obs_valid, 32'd1);
        end
        ordy = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            chk("bp_resume", obs_data, 32'(exp_b[i]));
        end
        step();
        chk("bp_rows", obs_rows, 32'd2);

        // Back-to-back rows with load_valid held.
        lv = 1'b1; ld = 32'h44332211;
        step();
        ld = 32'hDDCCBBAA;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) lv = 1'b0;
            step();
            chk("b2b_valid", obs_valid, 32'd1);
            chk("b2b_data", obs_data, 32'(exp_b[i]));
            if (i < 4 && obs_lr == 32'd1) pulses++;
            chk("b2b_load_ready", obs_lr, 32'(i == 3 || i == 7));
        end
        chk("b2b_pulses", 32'(pulses), 32'd1);
        step();
        chk("b2b_rows", obs_rows, 32'd4);

        // Load offered mid-row is held off until the last-byte handshake.
        lv = 1'b1; ld = 32'h44332211;
        step();
        lv = 1'b0;
        step();
        lv = 1'b1; ld = 32'hFFFFFFFF;
        step();
        chk("blk_load_ready", obs_lr, 32'd0);
        chk("blk_data", obs_data, 32'h22);
        chk("blk_index", obs_idx, 32'd1);
        step();
        chk("blk_load_ready2", obs_lr, 32'd0);
        step();
        chk("blk_take", obs_lr, 32'd1);
        chk("blk_last_data", obs_data, 32'h44);
        lv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("blk_new_data", obs_data, 32'hFF);
            chk("blk_new_index", obs_idx, 32'(i));
        end
        step();
        chk("blk_rows", obs_rows, 32'd6);

        // Reset while 0x33 is shown.
        lv = 1'b1; ld = 32'h44332211;
        step();
        lv = 1'b0;
        step();
        step();
        chk("mid_pre", obs_data, 32'h22);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("mid_rst_valid", obs_valid, 32'd0);
            chk("mid_rst_rows", obs_rows, 32'd0);
        end
        rst = 1'b1;
        step();
        chk("mid_rel_load_ready", obs_lr, 32'd1);
        chk("mid_rel_data", obs_data, 32'd0);
        lv = 1'b1; ld = 32'hA1B2C3D4;
        step();
        lv = 1'b0;
        step();
        chk("mid_new0", obs_data, 32'hD4);
        step();
        chk("mid_new1", obs_data, 32'hC3);
        step();
        step();
        chk("mid_new3", obs_data, 32'hA1);
        step();
        chk("mid_rows", obs_rows, 32'd1);

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 299) != 0);
            lv   = ($urandom_range(0, 2) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            ld   = $urandom;
            step();
        end

        // Counter wrap from 0xFFFF.
        rst = 1'b1; lv = 1'b0; ordy = 1'b1;
        for (int i = 0; i < NL + 1; i++) step();
        force dut.r_rows_done = 16'hFFFF;
        m_rows = 16'hFFFF;
        step();
        step();
        release dut.r_rows_done;
        step();
        chk("wrap_pre", obs_rows, 32'hFFFF);
        lv = 1'b1; ld = 32'h04030201;
        step();
        lv = 1'b0;
        for (int i = 0; i < NL; i++) step();
        step();
        chk("wrap_rows", obs_rows, 32'h0);
        chk("wrap_idle", obs_valid, 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
